lfsr_checker: RTL and testbench

//  Receive-side checker for the 32-bit LFSR pattern stream. Takes sampled 32-bit

---
 rtl/lfsr_checker.sv | 141 ++++++++++++++
 tb/tb_lfsr_checker.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// Receive-side checker for a 32-bit LFSR pattern stream.
// Synchronises to the incoming sequence, then flywheels its own prediction and counts mismatching words.
module lfsr_checker #(
  parameter int unsigned LOCK_MATCHES  = 4,
  parameter int unsigned UNLOCK_ERRORS = 3,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic [31:0]      data_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             error_o,
  output logic [CNT_W-1:0] err_count_o
);

  localparam int unsigned MW = $clog2(LOCK_MATCHES + 1);
  localparam int unsigned EW = $clog2(UNLOCK_ERRORS + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {s[30:0], s[27] ^ s[23] ^ s[19] ^ s[18] ^ s[15] ^ s[11] ^ s[7] ^ s[4] ^ s[1]};
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_pred;
  logic [31:0]      w_pred_nxt;
  logic [MW-1:0]    r_match_cnt;
  logic [MW-1:0]    w_match_nxt;
  logic [MW-1:0]    w_match_inc;
  logic [EW-1:0]    r_consec_err;
  logic [EW-1:0]    w_consec_nxt;
  logic [EW-1:0]    w_consec_inc;
  logic             w_err_evt;
  logic             w_data_match;
  logic             r_locked;
  logic             r_error;
  logic [CNT_W-1:0] r_err_count;

  assign w_data_match = (data_i == r_pred);
  assign w_match_inc  = MW'(r_match_cnt + MW'(1));
  assign w_consec_inc = EW'(r_consec_err + EW'(1));

  // State and prediction registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state      <= HUNT;
      r_pred       <= '0;
      r_match_cnt  <= '0;
      r_consec_err <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_pred       <= w_pred_nxt;
      r_match_cnt  <= w_match_nxt;
      r_consec_err <= w_consec_nxt;
    end
  end

  // Next-state: seed in HUNT, verify in ACQUIRE, flywheel in LOCKED
  always_comb begin
    w_state_nxt  = r_state;
    w_pred_nxt   = r_pred;
    w_match_nxt  = r_match_cnt;
    w_consec_nxt = r_consec_err;
    w_err_evt    = 1'b0;
    if (valid_i) begin
      unique case (r_state)
        HUNT: begin
          if (data_i != '0) begin
            w_pred_nxt  = lfsr_next(data_i);
            w_match_nxt = '0;
            w_state_nxt = ACQUIRE;
          end
        end
        ACQUIRE: begin
          w_pred_nxt = lfsr_next(data_i);
          if (w_data_match) begin
            if (w_match_inc == MW'(LOCK_MATCHES)) begin
              w_state_nxt  = LOCKED;
              w_match_nxt  = '0;
              w_consec_nxt = '0;
            end else begin
              w_match_nxt = w_match_inc;
            end
          end else begin
            w_match_nxt = '0;
            if (data_i == '0) begin
              w_state_nxt = HUNT;
            end
          end
        end
        LOCKED: begin
          w_pred_nxt = lfsr_next(r_pred);
          if (w_data_match) begin
            w_consec_nxt = '0;
          end else begin
            w_err_evt = 1'b1;
            if (w_consec_inc == EW'(UNLOCK_ERRORS)) begin
              w_consec_nxt = '0;
              w_state_nxt  = HUNT;
            end else begin
              w_consec_nxt = w_consec_inc;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  // Registered status outputs; a mismatch coinciding with clear still counts
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_locked    <= 1'b0;
      r_error     <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_locked <= (w_state_nxt == LOCKED);
      r_error  <= w_err_evt;
      if (clear_i) begin
        r_err_count <= w_err_evt ? CNT_W'(1) : '0;
      end else if (w_err_evt && (r_err_count != '1)) begin
        r_err_count <= CNT_W'(r_err_count + CNT_W'(1));
      end
    end
  end

  assign locked_o    = r_locked;
  assign error_o     = r_error;
  assign err_count_o = r_err_count;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker: lock, single/burst errors, gaps, saturation, async reset.
module tb_lfsr_checker;

  localparam logic [31:0] SEED = 32'h00144FDE;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        clear_i = 1'b0;
  logic        locked_o, error_o;
  logic [15:0] err_count_o;
  logic        locked4, error4;
  logic [3:0]  err_count4;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] gen;

  always #5 clk_i = ~clk_i;

  lfsr_checker u_dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
    .locked_o(locked_o), .error_o(error_o), .err_count_o(err_count_o)
  );

  lfsr_checker #(.CNT_W(4)) u_dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .data_i(data_i), .clear_i(clear_i),
    .locked_o(locked4), .error_o(error4), .err_count_o(err_count4)
  );

  function automatic logic [31:0] f(input logic [31:0] s);
    f = {s[30:0], s[27] ^ s[23] ^ s[19] ^ s[18] ^ s[15] ^ s[11] ^ s[7] ^ s[4] ^ s[1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called at a negedge; applies one cycle of inputs and returns at the next negedge
  task automatic step(input logic v, input logic [31:0] d, input logic clr);
    valid_i = v;
    data_i  = d;
    clear_i = clr;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    clear_i = 1'b0;
  endtask

  task automatic clean_beat();
    step(1'b1, gen, 1'b0);
    gen = f(gen);
  endtask

  task automatic bad_beat();
    step(1'b1, gen ^ 32'h1, 1'b0);
    gen = f(gen);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    valid_i = 1'b0;
    clear_i = 1'b0;
    @(negedge clk_i);
    chk("rst_locked", 32'(locked_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_count", 32'(err_count_o), 32'd0);
    reset_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic lock_up(input string tag);
    for (int i = 1; i <= 5; i++) begin
      clean_beat();
      chk(tag, 32'(locked_o), (i == 5) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int errs_seen;
    int beats;

    // 1: clean stream locks after seed + 4 matches, then runs error-free
    do_reset();
    gen = SEED;
    lock_up("t1_lock");
    errs_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      clean_beat();
      if (error_o !== 1'b0 || locked_o !== 1'b1) errs_seen++;
    end
    chk("t1_clean_run", 32'(errs_seen), 32'd0);
    chk("t1_count", 32'(err_count_o), 32'd0);

    // 2: single bit flip gives one pulse and keeps lock
    bad_beat();
    chk("t2_err", 32'(error_o), 32'd1);
    chk("t2_count", 32'(err_count_o), 32'd1);
    chk("t2_locked", 32'(locked_o), 32'd1);
    clean_beat();
    chk("t2_err_clear", 32'(error_o), 32'd0);
    for (int i = 0; i < 20; i++) clean_beat();
    chk("t2_count_hold", 32'(err_count_o), 32'd1);
    chk("t2_locked_hold", 32'(locked_o), 32'd1);

    // 3: clear on an idle cycle, then 3 consecutive errors drop lock
    step(1'b0, 32'hDEADBEEF, 1'b1);
    chk("t3_clear", 32'(err_count_o), 32'd0);
    chk("t3_clear_lock", 32'(locked_o), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      bad_beat();
      chk("t3_err", 32'(error_o), 32'd1);
      chk("t3_locked", 32'(locked_o), (i == 3) ? 32'd0 : 32'd1);
    end
    chk("t3_count", 32'(err_count_o), 32'd3);
    lock_up("t3_relock");
    chk("t3_count_after", 32'(err_count_o), 32'd3);

    // 4: random valid gaps with garbage idle data; same beat count to lock
    do_reset();
    gen = SEED;
    beats = 0;
    errs_seen = 0;
    while (beats < 200) begin
      if (($urandom % 2) == 0) begin
        step(1'b0, $urandom, 1'b0);
      end else begin
        clean_beat();
        beats++;
        if (beats == 4) chk("t4_pre_lock", 32'(locked_o), 32'd0);
        if (beats == 5) chk("t4_lock", 32'(locked_o), 32'd1);
      end
      if (error_o !== 1'b0) errs_seen++;
    end
    chk("t4_errs", 32'(errs_seen), 32'd0);
    chk("t4_count", 32'(err_count_o), 32'd0);
    chk("t4_locked_end", 32'(locked_o), 32'd1);
    do_reset();
    for (int i = 0; i < 50; i++) step(1'b1, 32'h0, 1'b0);
    chk("t4_zero_lock", 32'(locked_o), 32'd0);
    chk("t4_zero_count", 32'(err_count_o), 32'd0);
    gen = SEED;
    lock_up("t4_after_zero");

    // 5: 4-bit counter saturates at 15, clear with a same-cycle error gives 1
    do_reset();
    gen = SEED;
    lock_up("t5_lock");
    for (int i = 0; i < 15; i++) begin
      bad_beat();
      clean_beat();
    end
    chk("t5_count15", 32'(err_count4), 32'd15);
    chk("t5_locked", 32'(locked4), 32'd1);
    bad_beat();
    chk("t5_sat_err", 32'(error4), 32'd1);
    chk("t5_sat_hold", 32'(err_count4), 32'd15);
    clean_beat();
    step(1'b1, gen ^ 32'h8000_0001, 1'b1);
    gen = f(gen);
    chk("t5_clr_err_count", 32'(err_count4), 32'd1);
    chk("t5_clr_err_pulse", 32'(error4), 32'd1);
    chk("t5_clr_wide", 32'(err_count_o), 32'd1);

    // 6: async reset between edges clears outputs immediately
    do_reset();
    gen = SEED;
    lock_up("t6_lock");
    bad_beat();
    chk("t6_pre_err", 32'(error_o), 32'd1);
    #2 reset_i = 1'b1;
    #1;
    chk("t6_async_locked", 32'(locked_o), 32'd0);
    chk("t6_async_error", 32'(error_o), 32'd0);
    chk("t6_async_count", 32'(err_count_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(negedge clk_i);
    gen = SEED;
    lock_up("t6_relock");
    chk("t6_count_after", 32'(err_count_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
